// File: rtl/cache_controller.sv
// Sequencing FSM for the direct-mapped data cache: read-miss block fill, write-through stores.
// Optional read hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic        hit_miss,
    input  logic        dm_ready,
    output logic        stall,
    output logic        rd_en_cm,
    output logic        wr_en_cm,
    output logic        mem_to_cache_en,
    output logic        dm_rd_en,
    output logic        dm_wr_en
`ifdef CACHE_STATS_EN
   ,output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    // state   | meaning
    // IDLE    | accept requests; read hits complete here without stall
    // RD_MISS | block read outstanding in data memory
    // FILL    | one-cycle line fill from the memory bus
    // WR_WAIT | write-through word outstanding in data memory
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        FILL    = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = r_state;
        stall           = 1'b0;
        rd_en_cm        = 1'b0;
        wr_en_cm        = 1'b0;
        mem_to_cache_en = 1'b0;
        dm_rd_en        = 1'b0;
        dm_wr_en        = 1'b0;
        // Outputs held quiet during reset so an aborted access never touches the cache
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (cpu_wr) begin
                        stall    = 1'b1;
                        dm_wr_en = 1'b1;
                        wr_en_cm = hit_miss;
                        w_next   = WR_WAIT;
                    end else if (cpu_rd) begin
                        if (hit_miss) begin
                            rd_en_cm = 1'b1;
                        end else begin
                            stall    = 1'b1;
                            dm_rd_en = 1'b1;
                            w_next   = RD_MISS;
                        end
                    end
                end
                RD_MISS: begin
                    stall    = 1'b1;
                    dm_rd_en = 1'b1;
                    if (dm_ready) begin
                        w_next = FILL;
                    end
                end
                FILL: begin
                    stall           = 1'b1;
                    mem_to_cache_en = 1'b1;
                    w_next          = IDLE;
                end
                WR_WAIT: begin
                    dm_wr_en = 1'b1;
                    if (dm_ready) begin
                        w_next = IDLE;
                    end else begin
                        stall = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;
    logic        w_miss_start;

    assign w_miss_start = (r_state == IDLE) && (w_next == RD_MISS);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= 16'd0;
            r_miss_count <= 16'd0;
        end else begin
            if (rd_en_cm && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_miss_start && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: IDLE decode vector table plus multi-cycle sequences,
// with a per-cycle expected-output scoreboard. Counter checks are built when CACHE_STATS_EN is defined.
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpu_rd = 1'b0, cpu_wr = 1'b0, hit_miss = 1'b0, dm_ready = 1'b0;
    logic stall, rd_en_cm, wr_en_cm, mem_to_cache_en, dm_rd_en, dm_wr_en;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .hit_miss(hit_miss), .dm_ready(dm_ready), .stall(stall),
        .rd_en_cm(rd_en_cm), .wr_en_cm(wr_en_cm), .mem_to_cache_en(mem_to_cache_en),
        .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en)
`ifdef CACHE_STATS_EN
       ,.hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    // {stall, rd_en_cm, wr_en_cm, mem_to_cache_en, dm_rd_en, dm_wr_en}
    typedef struct {
        logic [5:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_HIT    = 6'b010000;
    localparam logic [5:0] O_MISS   = 6'b100010;
    localparam logic [5:0] O_FILL   = 6'b100100;
    localparam logic [5:0] O_WR_HIT = 6'b101001;
    localparam logic [5:0] O_WR_STL = 6'b100001;
    localparam logic [5:0] O_WR_END = 6'b000001;

    // Outputs sampled at the falling edge, mid-cycle, against the queued expectation
    always @(negedge clk) begin
        logic [5:0] act;
        exp_t       e;
        act = {stall, rd_en_cm, wr_en_cm, mem_to_cache_en, dm_rd_en, dm_wr_en};
        n_tests++;
        if ($countones({rd_en_cm, wr_en_cm, mem_to_cache_en}) > 1) begin
            n_fail++;
            $display("FAIL onehot_enables: got rd/wr/fill=%b, required at most one set",
                     {rd_en_cm, wr_en_cm, mem_to_cache_en});
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: outputs {stall,rd,wr,fill,dmrd,dmwr} got %b required %b",
                         e.name, act, e.exp);
            end
        end
    end

    task automatic step(input logic r, input logic rd, input logic wr, input logic hm,
                        input logic rdy, input logic [5:0] exp, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; cpu_rd = rd; cpu_wr = wr; hit_miss = hm; dm_ready = rdy;
        e.exp = exp;
        e.name = name;
        exp_q.push_back(e);
    endtask

`ifdef CACHE_STATS_EN
    task automatic chk_cnt(input logic [15:0] eh, input logic [15:0] em, input string name);
        n_tests++;
        if (hit_count !== eh || miss_count !== em) begin
            n_fail++;
            $display("FAIL %s: hit/miss got %0d/%0d required %0d/%0d",
                     name, hit_count, miss_count, eh, em);
        end
    endtask
`endif

    typedef struct {
        logic       rd, wr, hm, rdy;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, O_NONE,   "idle_none"};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, O_NONE,   "idle_none_hm_rdy"};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, O_MISS,   "idle_rd_miss"};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, O_MISS,   "idle_rd_miss_rdy_ignored"};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, O_HIT,    "idle_rd_hit"};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, O_WR_STL, "idle_wr_miss"};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, O_WR_HIT, "idle_wr_hit"};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, O_WR_STL, "idle_rdwr_miss_is_write"};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, O_WR_HIT, "idle_rdwr_hit_is_write"};
        vecs[9] = '{1'b0, 1'b1, 1'b1, 1'b1, O_WR_HIT, "idle_wr_hit_rdy_ignored"};

        // Reset with a pending miss request: outputs must stay quiet
        step(1, 1, 0, 0, 0, O_NONE, "reset_quiet");
        step(1, 0, 0, 0, 0, O_NONE, "reset_quiet2");
        step(0, 0, 0, 0, 0, O_NONE, "post_reset_idle");
`ifdef CACHE_STATS_EN
        chk_cnt(0, 0, "reset_counters");
`endif

        // Read miss, dm_ready 3 cycles after RD_MISS entry: stall 6 cycles
        step(0, 1, 0, 0, 0, O_MISS, "rdmiss_detect");
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, O_MISS, "rdmiss_wait");
        step(0, 1, 0, 0, 1, O_MISS, "rdmiss_ready");
        step(0, 1, 0, 0, 0, O_FILL, "rdmiss_fill");
        step(0, 1, 0, 1, 0, O_HIT,  "rdmiss_complete");
        step(0, 0, 0, 0, 0, O_NONE, "rdmiss_after");
`ifdef CACHE_STATS_EN
        chk_cnt(1, 1, "cnt_after_miss");
`endif

        // Four back-to-back hits
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0, O_HIT, "hit_burst");
        step(0, 0, 0, 0, 0, O_NONE, "hit_burst_after");
`ifdef CACHE_STATS_EN
        chk_cnt(5, 1, "cnt_after_hits");
`endif

        // Write hit, dm_ready one cycle into WR_WAIT
        step(0, 0, 1, 1, 0, O_WR_HIT, "wrhit_issue");
        step(0, 0, 1, 1, 0, O_WR_STL, "wrhit_wait");
        step(0, 0, 1, 1, 1, O_WR_END, "wrhit_retire");
        step(0, 0, 0, 0, 0, O_NONE,   "wrhit_after");

        // Write miss: no cache write, no counter change
        step(0, 0, 1, 0, 0, O_WR_STL, "wrmiss_issue");
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 0, O_WR_STL, "wrmiss_wait");
        step(0, 0, 1, 0, 1, O_WR_END, "wrmiss_retire");
        step(0, 0, 0, 0, 0, O_NONE,   "wrmiss_after");
`ifdef CACHE_STATS_EN
        chk_cnt(5, 1, "cnt_after_writes");
`endif

        // Read and write together: write wins, retires immediately
        step(0, 1, 1, 1, 0, O_WR_HIT, "rdwr_issue");
        step(0, 1, 1, 1, 1, O_WR_END, "rdwr_retire");
        step(0, 0, 0, 0, 0, O_NONE,   "rdwr_after");
`ifdef CACHE_STATS_EN
        chk_cnt(5, 1, "cnt_after_rdwr");
`endif

        // Reset during RD_MISS aborts; no FILL afterward
        step(0, 1, 0, 0, 0, O_MISS, "abort_detect");
        step(0, 1, 0, 0, 0, O_MISS, "abort_rdmiss");
        step(1, 1, 0, 0, 1, O_NONE, "abort_reset");
        step(0, 0, 0, 0, 1, O_NONE, "abort_no_fill");
        step(0, 1, 0, 0, 0, O_MISS, "abort_back_in_idle");
        step(1, 0, 0, 0, 0, O_NONE, "abort_reset2");
        step(0, 0, 0, 0, 0, O_NONE, "abort_after");
`ifdef CACHE_STATS_EN
        chk_cnt(0, 0, "cnt_cleared_by_reset");
`endif

        // IDLE decode table, each vector entered fresh from reset
        foreach (vecs[i]) begin
            step(1, 0, 0, 0, 0, O_NONE, "table_reset");
            step(0, vecs[i].rd, vecs[i].wr, vecs[i].hm, vecs[i].rdy, vecs[i].exp, vecs[i].name);
        end
        step(1, 0, 0, 0, 0, O_NONE, "table_reset_end");
        step(0, 0, 0, 0, 0, O_NONE, "table_end");

`ifdef CACHE_STATS_EN
        // Drive hit counter to saturation, then one more hit
        for (int i = 0; i < 65535; i++) step(0, 1, 0, 1, 0, O_HIT, "sat_fill");
        step(0, 0, 0, 0, 0, O_NONE, "sat_pause");
        chk_cnt(16'hFFFF, 0, "hit_at_max");
        step(0, 1, 0, 1, 0, O_HIT, "sat_extra_hit");
        step(0, 0, 0, 0, 0, O_NONE, "sat_after");
        chk_cnt(16'hFFFF, 0, "hit_saturated");
`endif

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
